// File: rtl/axi_lite_pkg.sv
// Shared constants for the AXI-Lite control slave: response codes, register
// offsets, control/status bit positions and the channel FSM state types.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register index as decoded from addr[3:2]
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_DATA_IN  = 2'd2;
    localparam logic [1:0] REG_DATA_OUT = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_START_BIT  = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

endpackage

// File: rtl/axi_lite_ctrl_slave.sv
// AXI-Lite register slave exposing CTRL/STATUS/DATA_IN/DATA_OUT to a core.
// Independent write and read channel FSMs; AW and W may arrive in any order.
module axi_lite_ctrl_slave
    import axi_lite_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [AXI_ADDR_WIDTH-1:0]     AWADDR,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]     ARADDR,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic                          core_en_o,
    output logic                          core_start_o,
    input  logic                          core_busy_i,
    input  logic                          core_done_i,
    output logic [31:0]                   core_data_o,
    input  logic [31:0]                   core_data_i
);

    localparam int NB = AXI_DATA_WIDTH / 8;

    w_state_e                    w_state_q, w_state_d;
    r_state_e                    r_state_q, r_state_d;
    logic                        aw_held_q, aw_held_d;
    logic                        w_held_q, w_held_d;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]               wstrb_q, wstrb_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic                        rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                        en_q, en_d;
    logic                        start_q, start_d;
    logic                        done_q, done_d;
    logic [31:0]                 data_in_q, data_in_d;

    logic                        aw_fire, w_fire, ar_fire;
    logic                        wr_en, done_clr;
    logic [AXI_ADDR_WIDTH-1:0]   wr_addr;
    logic [AXI_DATA_WIDTH-1:0]   wr_data;
    logic [NB-1:0]               wr_strb;
    logic [AXI_DATA_WIDTH-1:0]   rd_word;
    logic                        unused_addr_bits;

    // Ready is forced low combinationally while reset is asserted
    assign AWREADY = ~reset & (w_state_q == W_IDLE) & ~aw_held_q;
    assign WREADY  = ~reset & (w_state_q == W_IDLE) & ~w_held_q;
    assign ARREADY = ~reset & (r_state_q == R_IDLE);

    assign aw_fire = AWVALID & AWREADY;
    assign w_fire  = WVALID & WREADY;
    assign ar_fire = ARVALID & ARREADY;

    assign wr_addr = aw_held_q ? awaddr_q : AWADDR;
    assign wr_data = w_held_q  ? wdata_q  : WDATA;
    assign wr_strb = w_held_q  ? wstrb_q  : WSTRB;

    assign unused_addr_bits = ^{wr_addr[1:0], ARADDR[1:0]};

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = AWADDR;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                if ((aw_held_q | aw_fire) && (w_held_q | w_fire)) begin
                    wr_en     = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = (wr_addr[3:2] == REG_DATA_OUT) ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        start_d   = 1'b0;
        data_in_d = data_in_q;
        done_clr  = 1'b0;
        if (wr_en) begin
            case (wr_addr[3:2])
                REG_CTRL: begin
                    if (wr_strb[0]) begin
                        en_d    = wr_data[CTRL_EN_BIT];
                        start_d = wr_data[CTRL_START_BIT];
                    end
                end
                REG_STATUS: done_clr = wr_strb[0] & wr_data[STATUS_DONE_BIT];
                REG_DATA_IN: begin
                    for (int i = 0; i < NB; i++) begin
                        if (wr_strb[i]) data_in_d[8*i +: 8] = wr_data[8*i +: 8];
                    end
                end
                default: ;
            endcase
        end
        // A new done pulse outranks a simultaneous clear
        done_d = core_done_i | (done_q & ~done_clr);
    end

    always_comb begin
        rd_word = '0;
        case (ARADDR[3:2])
            REG_CTRL:    rd_word[CTRL_EN_BIT] = en_q;
            REG_STATUS: begin
                rd_word[STATUS_BUSY_BIT] = core_busy_i;
                rd_word[STATUS_DONE_BIT] = done_q;
            end
            REG_DATA_IN: rd_word = data_in_q;
            default:     rd_word = core_data_i;
        endcase
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rdata_d   = rd_word;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            data_in_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            en_q      <= en_d;
            start_q   <= start_d;
            done_q    <= done_d;
            data_in_q <= data_in_d;
        end
    end

    assign BVALID       = bvalid_q;
    assign BRESP        = bresp_q;
    assign RVALID       = rvalid_q;
    assign RDATA        = rdata_q;
    assign RRESP        = RESP_OKAY;
    assign core_en_o    = en_q;
    assign core_start_o = start_q;
    assign core_data_o  = data_in_q;

endmodule

// File: tb/tb_axi_lite_ctrl_slave.sv
// Directed bench for axi_lite_ctrl_slave: inputs change after the falling
// edge, outputs are sampled on the falling edge.
module tb_axi_lite_ctrl_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        core_en_o;
    logic        core_start_o;
    logic        core_busy_i;
    logic        core_done_i;
    logic [31:0] core_data_o;
    logic [31:0] core_data_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_lite_ctrl_slave #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .core_en_o(core_en_o), .core_start_o(core_start_o),
        .core_busy_i(core_busy_i), .core_done_i(core_done_i),
        .core_data_o(core_data_o), .core_data_i(core_data_i)
    );

    // Full write with BREADY=1; resp is 2'bxx on timeout.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        logic aw_ok, w_ok;
        int   t;
        @(negedge clk);
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1; BREADY = 1'b1;
        t = 0;
        while ((AWVALID || WVALID) && t < 20) begin
            aw_ok = AWVALID && AWREADY;
            w_ok  = WVALID && WREADY;
            @(posedge clk); #1;
            if (aw_ok) AWVALID = 1'b0;
            if (w_ok)  WVALID  = 1'b0;
            @(negedge clk);
            t++;
        end
        t = 0;
        while (!BVALID && t < 20) begin
            @(negedge clk);
            t++;
        end
        resp = BRESP;
        if (!BVALID) begin
            n_cmp++; n_bad++;
            $display("FAIL write_timeout addr=%h: BVALID never seen, required 1", a);
            resp = 2'bxx;
            AWVALID = 1'b0; WVALID = 1'b0;
        end
        @(posedge clk); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int t;
        @(negedge clk);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        t = 0;
        while (!ARREADY && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        ARVALID = 1'b0;
        @(negedge clk);
        t = 0;
        while (!RVALID && t < 20) begin
            @(negedge clk);
            t++;
        end
        d = RDATA;
        if (!RVALID) begin
            n_cmp++; n_bad++;
            $display("FAIL read_timeout addr=%h: RVALID never seen, required 1", a);
            d = 'x;
        end
        @(posedge clk); #1;
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ready: got %b required 000", {AWREADY, WREADY, ARREADY});
        end
        n_cmp++;
        if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0) begin
            n_bad++; $display("FAIL reset_valid_resp: got %b required 000000", {BVALID, RVALID, BRESP, RRESP});
        end
        n_cmp++;
        if ({core_en_o, core_start_o, core_data_o, RDATA} !== 66'b0) begin
            n_bad++; $display("FAIL reset_regs: en=%b start=%b data=%h rdata=%h required all 0",
                              core_en_o, core_start_o, core_data_o, RDATA);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_bad++; $display("FAIL post_reset_ready: got %b required 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_same_cycle_write();
        logic [31:0] rd;
        @(negedge clk);
        AWADDR = 4'h8; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            n_bad++; $display("FAIL same_cycle_bresp: bvalid=%b bresp=%b required 1/00", BVALID, BRESP);
        end
        n_cmp++;
        if (core_data_o !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL same_cycle_data: got %h required deadbeef", core_data_o);
        end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (BVALID !== 1'b0) begin
            n_bad++; $display("FAIL same_cycle_bvalid_drop: got %b required 0", BVALID);
        end
        axi_read(4'h8, rd);
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL same_cycle_readback: got %h required deadbeef", rd);
        end
    endtask

    task automatic test_w_before_aw();
        @(negedge clk);
        WDATA = 32'h000000AA; WSTRB = 4'h1; WVALID = 1'b1; BREADY = 1'b1;
        @(posedge clk); #1;
        WVALID = 1'b0; WDATA = 32'h12345678; WSTRB = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (BVALID !== 1'b0 || WREADY !== 1'b0 || AWREADY !== 1'b1) begin
                n_bad++; $display("FAIL w_first_wait%0d: bvalid=%b wready=%b awready=%b required 0/0/1",
                                  c, BVALID, WREADY, AWREADY);
            end
        end
        @(negedge clk);
        AWADDR = 4'h8; AWVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            n_bad++; $display("FAIL w_first_bresp: bvalid=%b bresp=%b required 1/00", BVALID, BRESP);
        end
        n_cmp++;
        if (core_data_o !== 32'hDEADBEAA) begin
            n_bad++; $display("FAIL w_first_strb_data: got %h required deadbeaa", core_data_o);
        end
        @(posedge clk); #1;
        BREADY = 1'b0;
    endtask

    task automatic test_ctrl_start();
        logic [31:0] rd;
        logic [1:0]  resp;
        @(negedge clk);
        AWADDR = 4'h0; AWVALID = 1'b1; WDATA = 32'h3; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (core_start_o !== 1'b1 || core_en_o !== 1'b1) begin
            n_bad++; $display("FAIL ctrl_start_pulse: start=%b en=%b required 1/1", core_start_o, core_en_o);
        end
        @(posedge clk); #1;
        BREADY = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (core_start_o !== 1'b0) begin
                n_bad++; $display("FAIL ctrl_start_width%0d: got %b required 0", c, core_start_o);
            end
        end
        axi_read(4'h0, rd);
        n_cmp++;
        if (rd !== 32'h1) begin
            n_bad++; $display("FAIL ctrl_readback: got %h required 00000001", rd);
        end
        // Strobe-less write: no effect but still OKAY
        axi_write(4'h0, 32'h2, 4'h0, resp);
        n_cmp++;
        if (resp !== 2'b00 || core_en_o !== 1'b1 || core_start_o !== 1'b0) begin
            n_bad++; $display("FAIL ctrl_nostrb: resp=%b en=%b start=%b required 00/1/0", resp, core_en_o, core_start_o);
        end
    endtask

    task automatic test_status();
        logic [31:0] rd;
        logic [1:0]  resp;
        @(negedge clk);
        core_done_i = 1'b1;
        @(posedge clk); #1;
        core_done_i = 1'b0;
        axi_read(4'h4, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_bad++; $display("FAIL status_done_set: got %h required 00000002", rd);
        end
        core_busy_i = 1'b1;
        axi_read(4'h4, rd);
        core_busy_i = 1'b0;
        n_cmp++;
        if (rd !== 32'h3) begin
            n_bad++; $display("FAIL status_busy: got %h required 00000003", rd);
        end
        @(negedge clk);
        AWADDR = 4'h4; AWVALID = 1'b1; WDATA = 32'h2; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
        core_done_i = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; core_done_i = 1'b0;
        @(posedge clk); #1;
        BREADY = 1'b0;
        axi_read(4'h4, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_bad++; $display("FAIL status_set_wins: got %h required 00000002", rd);
        end
        axi_write(4'h4, 32'h2, 4'hF, resp);
        axi_read(4'h4, rd);
        n_cmp++;
        if (rd !== 32'h0 || resp !== 2'b00) begin
            n_bad++; $display("FAIL status_w1c: got %h resp=%b required 00000000/00", rd, resp);
        end
        core_data_i = 32'hCAFEF00D;
        axi_read(4'hC, rd);
        n_cmp++;
        if (rd !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL data_out_read: got %h required cafef00d", rd);
        end
    endtask

    task automatic test_slverr_stall();
        logic [31:0] rd;
        @(negedge clk);
        AWADDR = 4'hC; AWVALID = 1'b1; WDATA = 32'h55555555; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (BVALID !== 1'b1 || BRESP !== 2'b10 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
                n_bad++; $display("FAIL slverr_hold%0d: bvalid=%b bresp=%b awready=%b wready=%b required 1/10/0/0",
                                  c, BVALID, BRESP, AWREADY, WREADY);
            end
        end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            n_bad++; $display("FAIL slverr_release: bvalid=%b awready=%b required 0/1", BVALID, AWREADY);
        end
        axi_read(4'h8, rd);
        n_cmp++;
        if (rd !== 32'hDEADBEAA) begin
            n_bad++; $display("FAIL slverr_no_side_effect: got %h required deadbeaa", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        @(negedge clk);
        AWADDR = 4'h8; AWVALID = 1'b1; WDATA = 32'h11223344; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
        ARADDR = 4'hB; ARVALID = 1'b1; RREADY = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEAA || BVALID !== 1'b1) begin
            n_bad++; $display("FAIL concurrent_prewrite: rvalid=%b rdata=%h bvalid=%b required 1/deadbeaa/1",
                              RVALID, RDATA, BVALID);
        end
        @(posedge clk); #1;
        BREADY = 1'b0; RREADY = 1'b0;
        axi_read(4'h8, rd);
        n_cmp++;
        if (rd !== 32'h11223344) begin
            n_bad++; $display("FAIL concurrent_postwrite: got %h required 11223344", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        @(negedge clk);
        AWADDR = 4'h8; AWVALID = 1'b1; WDATA = 32'h99999999; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
        ARADDR = 4'h0; ARVALID = 1'b1; RREADY = 1'b0;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (BVALID !== 1'b1 || RVALID !== 1'b1) begin
            n_bad++; $display("FAIL mid_pre_reset: bvalid=%b rvalid=%b required 1/1", BVALID, RVALID);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (BVALID !== 1'b0 || RVALID !== 1'b0 || AWREADY !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_clear: bvalid=%b rvalid=%b awready=%b required 0/0/0",
                              BVALID, RVALID, AWREADY);
        end
        reset = 1'b0;
        axi_read(4'h0, rd);
        n_cmp++;
        if (rd !== 32'h0 || core_en_o !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_ctrl: got %h en=%b required 00000000/0", rd, core_en_o);
        end
        axi_read(4'h8, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_bad++; $display("FAIL mid_reset_data_in: got %h required 00000000", rd);
        end
        // A held W beat must be dropped by reset
        @(negedge clk);
        WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge clk); #1;
        WVALID = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (WREADY !== 1'b1 || AWREADY !== 1'b1) begin
            n_bad++; $display("FAIL held_w_discard: wready=%b awready=%b required 1/1", WREADY, AWREADY);
        end
        @(negedge clk);
        AWADDR = 4'h8; AWVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (BVALID !== 1'b0 || core_data_o !== 32'h0) begin
            n_bad++; $display("FAIL held_w_no_write: bvalid=%b data=%h required 0/00000000", BVALID, core_data_o);
        end
    endtask

    initial begin
        reset = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        core_busy_i = 1'b0; core_done_i = 1'b0; core_data_i = 32'h0;
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_ctrl_start();
        test_status();
        test_slverr_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_ctrl_slave.md
AXI_LITE_CTRL_SLAVE -- requirements
Module: axi_lite_ctrl_slave

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 32, AXI-Lite data width; only 32 is supported.
REQ-002 Parameter AXI_ADDR_WIDTH, default 4, byte address width; covers four 32-bit registers.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  single clock; all logic samples on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 AWADDR in AXI_ADDR_WIDTH, AWVALID in 1, AWREADY out 1  write address channel.
REQ-007 WDATA in AXI_DATA_WIDTH, WSTRB in AXI_DATA_WIDTH/8, WVALID in 1, WREADY out 1  write data channel.
REQ-008 BRESP out 2, BVALID out 1, BREADY in 1  write response channel.
REQ-009 ARADDR in AXI_ADDR_WIDTH, ARVALID in 1, ARREADY out 1  read address channel.
REQ-010 RDATA out AXI_DATA_WIDTH, RRESP out 2, RVALID out 1, RREADY in 1  read data channel.
REQ-011 core_en_o  out  1  level copy of CTRL.EN.
REQ-012 core_start_o  out  1  one-cycle start pulse.
REQ-013 core_busy_i  in  1  live busy from core.
REQ-014 core_done_i  in  1  done pulse from core.
REQ-015 core_data_o  out  32  DATA_IN register contents.
REQ-016 core_data_i  in  32  result word from core.

Function
REQ-017 Register map, decoded on addr[3:2], addr[1:0] ignored:
- 0x0 CTRL RW: bit0 EN; bit1 START is write-1-pulse and reads 0; other bits read 0.
- 0x4 STATUS: bit0 BUSY is live core_busy_i; bit1 DONE is sticky and write-1-to-clear; other bits read 0.
- 0x8 DATA_IN RW: byte-lane writes honour WSTRB.
- 0xC DATA_OUT RO: reads return core_data_i.
REQ-018 Write FSM states SHALL be W_IDLE and W_RESP.
- In W_IDLE, AWREADY=1 until an AW beat is held; WREADY=1 until a W beat is held.
- AW and W SHALL be accepted in either order or in the same cycle.
REQ-019 On the clock edge where both AW and W are held or handshaking, the block SHALL:
- apply the write;
- clear both held flags;
- set BVALID=1 and enter W_RESP, so BVALID is high in the following cycle.
REQ-020 In W_RESP, AWREADY=WREADY=0; BVALID and BRESP SHALL be held stable until BREADY=1, then the FSM returns to W_IDLE.
REQ-021 BRESP SHALL be OKAY (2'b00) for CTRL, STATUS and DATA_IN writes.
REQ-022 A write to DATA_OUT SHALL return SLVERR (2'b10) with no state change.
REQ-023 Read FSM states SHALL be R_IDLE and R_DATA.
- In R_IDLE, ARREADY=1.
- On the AR handshake, RDATA is registered and RVALID=1 in the next cycle.
- RDATA/RRESP SHALL be held until RREADY=1; RRESP is always OKAY.
REQ-024 The write and read FSMs SHALL operate independently, and concurrent read and write SHALL be allowed.
REQ-025 A read of a register written in the same edge SHALL return the pre-write value.
REQ-026 core_start_o SHALL be high exactly one cycle, the cycle after a CTRL write with WDATA[1]=1 and WSTRB[0]=1.
REQ-027 WSTRB lane 0 SHALL gate the CTRL and STATUS bit writes; WSTRB=0 SHALL still produce an OKAY response.
REQ-028 DONE SHALL set on core_done_i=1; if a W1C clear and core_done_i occur on the same edge, set SHALL win.

Reset
REQ-029 On reset the block SHALL set AWREADY=WREADY=ARREADY=0 during the reset cycle and 1 afterwards.
REQ-030 On reset: BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, CTRL=0, DONE=0, DATA_IN=0, core_start_o=0.
REQ-031 On reset: both FSMs SHALL return to IDLE and held AW/W beats SHALL be discarded, including mid-transaction.

Structure
REQ-032 Package axi_lite_pkg SHALL hold:
- resp codes OKAY/SLVERR;
- register offsets and CTRL/STATUS bit indices;
- the write and read FSM state enums.
REQ-033 The block SHALL be a single module with no sub-module; it is driven by the existing axi_lite_if.

Verification
REQ-034 AW and W in the same cycle to 0x8, WDATA=0xDEADBEEF, WSTRB=0xF -> BVALID one cycle later with OKAY; core_data_o=0xDEADBEEF; read 0x8 returns 0xDEADBEEF.
REQ-035 W first (WDATA=0x000000AA, WSTRB=0x1), AW three cycles later to 0x8 holding 0xDEADBEEF -> DATA_IN=0xDEADBEAA; BVALID appears only after AW.
REQ-036 Write 0x3 to 0x0 -> core_en_o=1; core_start_o high for exactly one cycle; read 0x0 returns 0x1.
REQ-037 core_done_i pulse, then read 0x4 -> 0x2; write 0x2 to 0x4 on the same edge as a second done pulse -> DONE remains 1.
REQ-038 Write to 0xC -> BRESP=SLVERR; with BREADY held low 5 cycles -> BVALID and BRESP stay stable and AWREADY=0.
REQ-039 Assert reset while in W_RESP and R_DATA -> BVALID=RVALID=0 next cycle; CTRL and DATA_IN read 0 afterwards.
